// File: rtl/uart_fpga_pkg.sv
// uart_fpga_pkg: shared frame-state encoding and serial line constants for the LArPix v3 UART link
package uart_fpga_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} frame_state_t;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   OVERSAMPLE = 4;
endpackage

// File: rtl/uart_fpga_rx_core.sv
// uart_fpga_rx_core: receive half, deserialises WIDTH-bit frames from PISO and holds the payload
//   clk, reset_n       : clock, async active-low reset
//   rx_in              : serial input, idle high
//   v3_mode            : 1 = one bit per clk, 0 = one bit per OVERSAMPLE clks
//   uld_rx_data        : host unload strobe, sets rx_empty
//   rx_data            : received payload bits [WIDTH-2:0]
//   rx_empty           : no unread word
//   parity_error       : held word failed odd parity
module uart_fpga_rx_core
    import uart_fpga_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_in,
    input  logic             v3_mode,
    input  logic             uld_rx_data,
    output logic [WIDTH-2:0] rx_data,
    output logic             rx_empty,
    output logic             parity_error
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(OVERSAMPLE);
    frame_state_t     state, state_n;
    logic [1:0]       sync;
    logic [CW-1:0]    cnt, cnt_n;
    logic [PW-1:0]    ph, ph_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             rx_s, sample, done;
    assign rx_s   = sync[1];
    // In oversampled mode ph is zeroed on the 2nd clock of the start cell, so
    // reaching OVERSAMPLE-1 lands on the 2nd clock of every following cell.
    assign sample = v3_mode || ph == PW'(OVERSAMPLE - 1);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ph_n    = sample ? '0 : ph + 1'b1;
        sreg_n  = sreg;
        done    = 1'b0;
        case (state)
            IDLE: begin
                ph_n  = '0;
                cnt_n = '0;
                if (rx_s == START_BIT) state_n = v3_mode ? DATA : START;
            end
            START: begin
                ph_n    = '0;
                state_n = (rx_s == START_BIT) ? DATA : IDLE;
            end
            DATA: if (sample) begin
                sreg_n = {rx_s, sreg[WIDTH-1:1]};
                cnt_n  = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_n = STOP;
            end
            STOP: if (sample) begin
                state_n = IDLE;
                done    = (rx_s == STOP_BIT);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync         <= 2'b11;
            state        <= IDLE;
            cnt          <= '0;
            ph           <= '0;
            sreg         <= '0;
            rx_data      <= '0;
            rx_empty     <= 1'b1;
            parity_error <= 1'b0;
        end else begin
            sync  <= {sync[0], rx_in};
            state <= state_n;
            cnt   <= cnt_n;
            ph    <= ph_n;
            sreg  <= sreg_n;
            if (done) begin
                rx_data      <= sreg[WIDTH-2:0];
                parity_error <= ~^sreg;
            end
            // a completing word beats a same-edge unload
            rx_empty <= done ? 1'b0 : uld_rx_data ? 1'b1 : rx_empty;
        end
    end
endmodule

// File: rtl/uart_fpga_link.sv
// uart_fpga_link: FPGA-side serial link to one LArPix v3 ASIC (transmit FSM here, receive in rx_core)
//   clk, reset_n                     : clock, async active-low reset
//   tx_data, ld_tx_data, tx_enable   : word to send (parity in MSB), load request, enable
//   enable_tx_dynamic_powerdown      : enables tx_powerdown indication
//   tx_dynamic_powerdown_cycles      : idle threshold N, powerdown after N+1 idle clocks
//   tx_out, tx_busy, tx_powerdown    : POSI line, frame in progress, idle indication
//   rx_in, v3_mode, uld_rx_data      : PISO line, bit-rate mode, unload strobe
//   rx_data, rx_empty, parity_error  : held payload and status
module uart_fpga_link
    import uart_fpga_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             ld_tx_data,
    input  logic             tx_enable,
    input  logic             enable_tx_dynamic_powerdown,
    input  logic [2:0]       tx_dynamic_powerdown_cycles,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_powerdown,
    input  logic             rx_in,
    input  logic             v3_mode,
    input  logic             uld_rx_data,
    output logic [WIDTH-2:0] rx_data,
    output logic             rx_empty,
    output logic             parity_error
);
    localparam int CW = $clog2(WIDTH);
    frame_state_t     state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [3:0]       idle_cnt;
    logic             out_n, load, last;
    assign load         = ld_tx_data && tx_enable && state == IDLE;
    assign tx_busy      = state != IDLE;
    assign last         = cnt == CW'(WIDTH - 1);
    assign tx_powerdown = enable_tx_dynamic_powerdown && idle_cnt > {1'b0, tx_dynamic_powerdown_cycles};
    // tx_out is registered: out_n is the level for the bit period after this edge
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        out_n   = STOP_BIT;
        case (state)
            IDLE: if (load) begin
                state_n = START;
                sreg_n  = tx_data;
                out_n   = START_BIT;
            end
            START: begin
                state_n = DATA;
                cnt_n   = '0;
                out_n   = sreg[0];
            end
            DATA: begin
                state_n = last ? STOP : DATA;
                cnt_n   = cnt + 1'b1;
                sreg_n  = sreg >> 1;
                out_n   = last ? STOP_BIT : sreg[1];
            end
            STOP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            tx_out   <= STOP_BIT;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            cnt      <= cnt_n;
            tx_out   <= out_n;
            idle_cnt <= (tx_busy || load) ? '0 : (&idle_cnt ? idle_cnt : idle_cnt + 1'b1);
        end
    end
    uart_fpga_rx_core #(.WIDTH(WIDTH)) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_in        (rx_in),
        .v3_mode      (v3_mode),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .parity_error (parity_error)
    );
endmodule

// File: tb/tb_uart_fpga_link.sv
// tb_uart_fpga_link: randomized self-checking bench for uart_fpga_link against a frame-level model
module tb_uart_fpga_link;
    localparam int WIDTH = 64;
    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             ld_tx_data = 1'b0;
    logic             tx_enable = 1'b1;
    logic             enable_tx_dynamic_powerdown = 1'b0;
    logic [2:0]       tx_dynamic_powerdown_cycles = 3'd0;
    logic             tx_out, tx_busy, tx_powerdown;
    logic             rx_in;
    logic             v3_mode = 1'b1;
    logic             uld_rx_data = 1'b0;
    logic [WIDTH-2:0] rx_data;
    logic             rx_empty, parity_error;
    logic             loop = 1'b0;
    logic             rx_drv = 1'b1;
    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-2:0] m_data = '0;
    logic             m_perr = 1'b0;
    logic             m_empty = 1'b1;

    assign rx_in = loop ? tx_out : rx_drv;
    always #5 clk = ~clk;

    uart_fpga_link #(.WIDTH(WIDTH)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .tx_data                     (tx_data),
        .ld_tx_data                  (ld_tx_data),
        .tx_enable                   (tx_enable),
        .enable_tx_dynamic_powerdown (enable_tx_dynamic_powerdown),
        .tx_dynamic_powerdown_cycles (tx_dynamic_powerdown_cycles),
        .tx_out                      (tx_out),
        .tx_busy                     (tx_busy),
        .tx_powerdown                (tx_powerdown),
        .rx_in                       (rx_in),
        .v3_mode                     (v3_mode),
        .uld_rx_data                 (uld_rx_data),
        .rx_data                     (rx_data),
        .rx_empty                    (rx_empty),
        .parity_error                (parity_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // model of a word received with a good stop bit
    task automatic model_complete(input logic [WIDTH-1:0] w);
        m_data  = w[WIDTH-2:0];
        m_perr  = ($countones(w) % 2) == 0;
        m_empty = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] w);
        tx_data    = w;
        ld_tx_data = 1'b1;
        tick();
        ld_tx_data = 1'b0;
    endtask

    task automatic unload();
        uld_rx_data = 1'b1;
        tick();
        uld_rx_data = 1'b0;
        m_empty = 1'b1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (tx_busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_rx(output int n);
        n = 0;
        while (rx_empty && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic drive_frame(input logic [WIDTH-1:0] w, input logic stop_bit, input int cpb);
        logic [WIDTH+1:0] f;
        f = {stop_bit, w, 1'b0};
        for (int i = 0; i < WIDTH + 2; i++) begin
            rx_drv = f[i];
            repeat (cpb) tick();
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        tests++; if (tx_out !== 1'b1) begin fails++; $display("FAIL reset_tx_out got %b exp 1", tx_out); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
        tests++; if (tx_powerdown !== 1'b0) begin fails++; $display("FAIL reset_pd got %b exp 0", tx_powerdown); end
        tests++; if (rx_data !== '0) begin fails++; $display("FAIL reset_rx_data got %h exp 0", rx_data); end
        tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL reset_rx_empty got %b exp 1", rx_empty); end
        tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL reset_perr got %b exp 0", parity_error); end
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_loopback_msb();
        int n;
        loop = 1'b1;
        v3_mode = 1'b1;
        do_load(64'h8000_0000_0000_0000);
        tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL lb_busy_rise got %b exp 1", tx_busy); end
        wait_idle(n);
        tests++; if (n != 66) begin fails++; $display("FAIL lb_busy_len got %0d exp 66", n); end
        wait_rx(n);
        tests++; if (n >= 40) begin fails++; $display("FAIL lb_rx_timeout waited %0d exp <40", n); end
        model_complete(64'h8000_0000_0000_0000);
        tests++; if (rx_data !== m_data) begin fails++; $display("FAIL lb_data got %h exp %h", rx_data, m_data); end
        tests++; if (parity_error !== m_perr) begin fails++; $display("FAIL lb_perr got %b exp %b", parity_error, m_perr); end
        tests++; if (rx_empty !== m_empty) begin fails++; $display("FAIL lb_empty got %b exp %b", rx_empty, m_empty); end
    endtask

    task automatic test_parity_unload();
        int n;
        unload();
        tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL pu_pre_unload got %b exp 1", rx_empty); end
        do_load('0);
        wait_idle(n);
        wait_rx(n);
        tests++; if (n >= 40) begin fails++; $display("FAIL pu_rx_timeout waited %0d exp <40", n); end
        model_complete('0);
        tests++; if (rx_data !== m_data) begin fails++; $display("FAIL pu_data got %h exp %h", rx_data, m_data); end
        tests++; if (parity_error !== m_perr) begin fails++; $display("FAIL pu_perr got %b exp %b", parity_error, m_perr); end
        unload();
        tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL pu_unload_empty got %b exp 1", rx_empty); end
        tests++; if (rx_data !== m_data) begin fails++; $display("FAIL pu_hold_data got %h exp %h", rx_data, m_data); end
        tests++; if (parity_error !== m_perr) begin fails++; $display("FAIL pu_hold_perr got %b exp %b", parity_error, m_perr); end
    endtask

    task automatic test_tx_sequence();
        logic [WIDTH-1:0] w;
        logic [WIDTH+1:0] seq;
        int               bad;
        loop = 1'b0;
        w = 64'h0123_4567_89AB_CDEF;
        seq = {1'b1, w, 1'b0};
        bad = 0;
        do_load(w);
        tests++; if (tx_out !== seq[0]) begin fails++; $display("FAIL seq_start got %b exp %b", tx_out, seq[0]); end
        for (int i = 1; i < WIDTH + 2; i++) begin
            ld_tx_data = (i == 20);
            tx_data = (i == 20) ? ~w : w;
            if (i == 30) tx_enable = 1'b0;
            tick();
            if (tx_out !== seq[i]) begin
                bad++;
                $display("FAIL seq_bit %0d got %b exp %b", i, tx_out, seq[i]);
            end
        end
        ld_tx_data = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL seq_total got %0d bad bits exp 0", bad); end
        tx_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin fails++; $display("FAIL seq_no_second got busy=%b out=%b exp 0/1", tx_busy, tx_out); end
        end
    endtask

    task automatic test_framing();
        loop = 1'b0;
        v3_mode = 1'b1;
        rx_drv = 1'b1;
        repeat (3) tick();
        drive_frame(rand_word(), 1'b0, 1);
        repeat (10) tick();
        tests++; if (rx_empty !== m_empty) begin fails++; $display("FAIL frm_empty got %b exp %b", rx_empty, m_empty); end
        tests++; if (rx_data !== m_data) begin fails++; $display("FAIL frm_data got %h exp %h", rx_data, m_data); end
        tests++; if (parity_error !== m_perr) begin fails++; $display("FAIL frm_perr got %b exp %b", parity_error, m_perr); end
    endtask

    task automatic test_oversample_reset();
        logic [WIDTH-2:0] payload;
        logic [WIDTH-1:0] w, w2;
        int               n;
        loop = 1'b0;
        v3_mode = 1'b0;
        rx_drv = 1'b1;
        repeat (8) tick();
        payload = 63'h2AAA_AAAA_AAAA_AAAA;
        w = {~^payload, payload};
        drive_frame(w, 1'b1, 4);
        wait_rx(n);
        tests++; if (n >= 40) begin fails++; $display("FAIL os_rx_timeout waited %0d exp <40", n); end
        model_complete(w);
        tests++; if (rx_data !== m_data) begin fails++; $display("FAIL os_data got %h exp %h", rx_data, m_data); end
        tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL os_perr got %b exp 0", parity_error); end
        repeat (4) tick();
        do_load(rand_word());
        w2 = rand_word();
        rx_drv = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            rx_drv = w2[i];
            repeat (4) tick();
        end
        tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL os_mid_busy got %b exp 1", tx_busy); end
        #2;
        reset_n = 1'b0;
        #1;
        m_data = '0; m_perr = 1'b0; m_empty = 1'b1;
        tests++; if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_powerdown !== 1'b0) begin fails++; $display("FAIL os_rst_tx got out=%b busy=%b pd=%b exp 1/0/0", tx_out, tx_busy, tx_powerdown); end
        tests++; if (rx_data !== m_data || rx_empty !== m_empty || parity_error !== m_perr) begin fails++; $display("FAIL os_rst_rx got data=%h empty=%b perr=%b exp 0/1/0", rx_data, rx_empty, parity_error); end
        rx_drv = 1'b1;
        v3_mode = 1'b1;
        reset_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_powerdown();
        int n;
        loop = 1'b0;
        tx_enable = 1'b1;
        enable_tx_dynamic_powerdown = 1'b1;
        tx_dynamic_powerdown_cycles = 3'd3;
        do_load(rand_word());
        wait_idle(n);
        tests++; if (n != 66) begin fails++; $display("FAIL pd_frame_len got %0d exp 66", n); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (tx_powerdown !== 1'b0) begin fails++; $display("FAIL pd_early idle %0d got %b exp 0", i, tx_powerdown); end
            tick();
        end
        tests++; if (tx_powerdown !== 1'b1) begin fails++; $display("FAIL pd_assert got %b exp 1", tx_powerdown); end
        do_load(rand_word());
        tests++; if (tx_powerdown !== 1'b0 || tx_busy !== 1'b1 || tx_out !== 1'b0) begin fails++; $display("FAIL pd_wake got pd=%b busy=%b out=%b exp 0/1/0", tx_powerdown, tx_busy, tx_out); end
        wait_idle(n);
        enable_tx_dynamic_powerdown = 1'b0;
        repeat (10) tick();
        tests++; if (tx_powerdown !== 1'b0) begin fails++; $display("FAIL pd_disabled got %b exp 0", tx_powerdown); end
        tx_enable = 1'b0;
        tx_data = rand_word();
        ld_tx_data = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin fails++; $display("FAIL pd_tx_disabled got busy=%b out=%b exp 0/1", tx_busy, tx_out); end
        end
        ld_tx_data = 1'b0;
        tx_enable = 1'b1;
        tick();
    endtask

    task automatic test_random_loopback();
        logic [WIDTH-1:0] w;
        int               n;
        loop = 1'b1;
        v3_mode = 1'b1;
        if (!rx_empty) unload();
        for (int k = 0; k < 5; k++) begin
            w = rand_word();
            do_load(w);
            wait_idle(n);
            tests++; if (n != 66) begin fails++; $display("FAIL rnd_len[%0d] got %0d exp 66", k, n); end
            wait_rx(n);
            model_complete(w);
            tests++; if (rx_data !== m_data || parity_error !== m_perr) begin fails++; $display("FAIL rnd_word[%0d] got %h/%b exp %h/%b", k, rx_data, parity_error, m_data, m_perr); end
            unload();
            tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL rnd_unload[%0d] got %b exp 1", k, rx_empty); end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b, c;
        int               n;
        loop = 1'b1;
        a = rand_word();
        b = rand_word();
        c = rand_word();
        do_load(a);
        wait_idle(n);
        do_load(b);
        wait_rx(n);
        model_complete(a);
        tests++; if (rx_data !== m_data || tx_busy !== 1'b1) begin fails++; $display("FAIL b2b_first got %h busy=%b exp %h busy=1", rx_data, tx_busy, m_data); end
        uld_rx_data = 1'b1;
        tick();
        tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL b2b_unload got %b exp 1", rx_empty); end
        n = 0;
        while (rx_empty && n < 200) begin
            n++;
            tick();
        end
        uld_rx_data = 1'b0;
        model_complete(b);
        tests++; if (n >= 200) begin fails++; $display("FAIL b2b_timeout waited %0d exp <200", n); end
        tests++; if (rx_empty !== 1'b0 || rx_data !== m_data || parity_error !== m_perr) begin fails++; $display("FAIL b2b_collision got %b/%h/%b exp 0/%h/%b", rx_empty, rx_data, parity_error, m_data, m_perr); end
        do_load(c);
        wait_idle(n);
        repeat (5) tick();
        model_complete(c);
        tests++; if (rx_empty !== 1'b0 || rx_data !== m_data || parity_error !== m_perr) begin fails++; $display("FAIL overrun got %b/%h/%b exp 0/%h/%b", rx_empty, rx_data, parity_error, m_data, m_perr); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback_msb();
        test_parity_unload();
        test_tx_sequence();
        test_framing();
        test_oversample_reset();
        test_powerdown();
        test_random_loopback();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_fpga_link.md
Name: uart_fpga_link

Overview:
- FPGA-side serial link to one LArPix v3 ASIC: a transmit half and a receive half sharing one clock and one reset.
- Transmit half serialises 64-bit configuration words onto the chip's POSI line.
- Receive half deserialises 64-bit packets from the chip's PISO line, checks odd parity, and holds the 63-bit payload for the host.
- Sits between the host/test sequencer and the chip pins; the host sees a load/busy handshake on transmit and an empty/unload handshake on receive.

Parameters:
- WIDTH, 64, serial word length in bits including the parity bit (MSB); rx payload is WIDTH-1 bits.

Ports:
- clk  in  1  system clock; bit clock in v3 mode.
- reset_n  in  1  asynchronous active-low reset.
- tx_data  in  WIDTH  word to send, LSB first; caller supplies the parity bit in bit WIDTH-1.
- ld_tx_data  in  1  load request, sampled on rising clk.
- tx_enable  in  1  transmitter enable.
- enable_tx_dynamic_powerdown  in  1  enables idle powerdown indication.
- tx_dynamic_powerdown_cycles  in  3  idle threshold N (see Behaviour).
- tx_out  out  1  serial output; idle high.
- tx_busy  out  1  frame in progress.
- tx_powerdown  out  1  transmitter idle/powered-down indication.
- rx_in  in  1  serial input; idle high.
- v3_mode  in  1  1 = one bit per clk; 0 = 4x oversampled (one bit per 4 clks).
- uld_rx_data  in  1  host unload strobe.
- rx_data  out  WIDTH-1  received payload, bits [WIDTH-2:0].
- rx_empty  out  1  1 = no unread word.
- parity_error  out  1  1 = held word failed odd parity.

Behaviour:
- Reset values: tx_out=1, tx_busy=0, tx_powerdown=0, rx_data=0, rx_empty=1, parity_error=0; both FSMs go to IDLE; reset mid-frame aborts the frame immediately.
- Frame format: start bit 0, WIDTH data bits LSB first, stop bit 1; WIDTH+2 bit times total.
- TX FSM states: IDLE, START, DATA, STOP.
- TX load: a load is accepted when ld_tx_data=1, tx_enable=1 and tx_busy=0 at a rising edge. On that edge tx_data is latched and tx_busy goes 1.
- TX timing: tx_out drives the start bit for the next clk, then bits 0..WIDTH-1 one per clk, then the stop bit. tx_busy returns to 0 on the edge ending the stop bit, so the next frame can begin back-to-back.
- TX ignored inputs: ld_tx_data while busy is ignored and not queued. tx_enable=0 holds tx_out=1 and blocks new loads; a frame already in flight completes.
- TX bit rate: one bit per clk regardless of v3_mode.
- tx_powerdown: with enable_tx_dynamic_powerdown=1, asserts after (N+1) consecutive idle clocks. It clears on the edge a load is accepted; no added latency to the start bit. With enable_tx_dynamic_powerdown=0 it is always 0.
- RX FSM states: IDLE, START, DATA, STOP.
- RX start detection:
  - v3_mode=1: a 0 sampled on rx_in in IDLE is the start bit; the next WIDTH clocks each sample one data bit; the following clk samples the stop bit.
  - v3_mode=0: start is qualified by 0 at the 2nd of 4 oversample clocks; every subsequent bit is sampled at the 2nd clock of its 4-clock cell.
  - rx_in passes through a 2-flop synchroniser in both modes. The added fixed latency is allowed; sample alignment must account for it.
- RX completion:
  - Stop bit = 1: rx_data <= bits [WIDTH-2:0], parity_error <= (XOR of all WIDTH bits == 0), i.e. odd parity required; rx_empty <= 0, all on the same edge.
  - Stop bit = 0 (framing error): word discarded, outputs unchanged, back to IDLE.
- Unload: uld_rx_data=1 at an edge sets rx_empty=1 on that edge. rx_data and parity_error hold their values until the next completed word.
- Overrun: a new word completing while rx_empty=0 overwrites rx_data/parity_error; rx_empty stays 0.
- Simultaneous unload and completion on the same edge: the new word wins, rx_empty=0.
- RX and TX are fully independent.

Decomposition:
- Package uart_fpga_pkg holds the frame-state enum (IDLE/START/DATA/STOP), the start/stop bit constants and the oversample ratio 4.
- Natural sub-module: uart_fpga_rx_core (receive half). The top instantiates it and contains the transmit FSM directly.

Test Plan:
- Loopback (tx_out->rx_in, v3_mode=1): load 64'h8000_0000_0000_0000 -> tx_busy high 66 clocks; rx_empty falls with rx_data=63'h0 and parity_error=0.
- Loopback, load 64'h0000_0000_0000_0000 -> rx_data=0, parity_error=1; pulse uld_rx_data -> rx_empty=1 next edge, rx_data still 0.
- Load 64'h0123_4567_89AB_CDEF -> tx_out sequence 0, then 1,1,1,1,0,1,1,1…, ending with stop bit 1. ld_tx_data repeated mid-frame -> no second frame.
- Framing: drive a frame with stop bit 0 -> rx_empty stays 1, rx_data unchanged.
- v3_mode=0: drive a frame at 4 clks/bit with payload 63'h2AAA_AAAA_AAAA_AAAA (parity bit set for odd parity) -> correct rx_data, parity_error=0. Assert reset_n mid-frame -> all outputs return to reset values immediately.
- Powerdown: enable=1, N=3, idle -> tx_powerdown=1 after 4 clks; load -> cleared that edge. tx_enable=0 -> load ignored, tx_out=1.
